demux_stream: RTL and testbench
===============================

# demux_stream

Parametrised, registered 1-to-CH stream demultiplexer with per-channel valid/ready handshakes. It is the next generation of the team's 1-to-4 combinational demux. It routes each accepted input word to one of CH output channels, either by an explicit select or in round-robin order. Each channel has a one-entry output register so downstream back-pressure is isolated per channel. It sits between a single producer and CH independent consumers in the datapath.

## Interface
- WIDTH, default 8: data width in bits (≥1).
- CH, default 4: number of output channels (≥2; need not be a power of two).
- SELW, default 2: select width; must equal ceil(log2(CH)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  SELW  target channel; used only when mode=0.
- mode  input  1  0 = explicit select, 1 = round-robin.
- out_valid  output  CH  per-channel word-held flag.
- out_ready  input  CH  per-channel consumer ready.
- out_data  output  CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- rr_ptr  output  SELW  next round-robin target channel.
- sel_err  output  1  one-cycle pulse when an out-of-range select is dropped.

## Operation
- Target channel: tgt = in_sel when mode=0; tgt = rr_ptr when mode=1.
- Per-channel state machine, two states:
  - EMPTY (out_valid[i]=0) moves to FULL on accept to channel i.
  - FULL moves to EMPTY when out_ready[i]=1 and there is no simultaneous accept to i.
  - FULL stays FULL on simultaneous drain and accept to i, and the register loads the new word.
- in_ready = 1 when tgt ≥ CH. Otherwise in_ready = !out_valid[tgt] | out_ready[tgt]. This is a combinational path from out_ready, which is permitted.
- Accept condition: in_valid & in_ready.
- Out-of-range select (mode=0, in_sel ≥ CH, reachable only when CH is not a power of two):
  - The word is consumed and dropped.
  - No channel changes.
  - sel_err=1 on the following cycle only.
- Round-robin:
  - On each accept with mode=1, rr_ptr advances by 1 and wraps from CH-1 to 0.
  - A stalled target blocks the input. The block never skips to another free channel.
  - rr_ptr holds when mode=0 and is not cleared by mode changes.
- Mode can change on any cycle. It affects tgt combinationally in that same cycle.
- out_data[i] is stable while out_valid[i]=1 and out_ready[i]=0.
- Channels not targeted are unaffected by input activity.

## Timing
- Reset values on the first rising edge with rst=1:
  - out_valid = 0
  - out_data = 0
  - rr_ptr = 0
  - sel_err = 0
  - in_ready then follows its combinational rule: 1 after reset.
- Reset mid-operation discards all held words without signalling an error.
- Latency: a word accepted at edge n is visible on out_valid/out_data after edge n.
- Throughput: one word per cycle sustained when the target consumer holds out_ready=1, including repeated hits to the same channel.
- sel_err is registered: asserted for exactly one cycle after the dropping edge.
- No combinational path from in_valid to out_valid.

## Test plan
- Reset, then drive in_sel 0,1,2,3 with data A0,A1,A2,A3 back-to-back, mode=0, all out_ready=1 -> each out_valid[i] pulses one cycle after its accept carrying Ai; in_ready stays 1 throughout.
- Back-pressure on channel 2 (out_ready[2]=0): send two words to channel 2 -> first is held stable, in_ready=0 for the second. Raise out_ready[2] -> second is accepted the same cycle and appears next cycle. Channels 0, 1 and 3 keep accepting meanwhile.
- mode=1, 6 words D0..D5, all ready -> routed to channels 0,1,2,3,0,1; rr_ptr ends at 2; in_sel is ignored.
- CH=3, SELW=2, mode=0, in_sel=3 with in_valid=1 -> in_ready=1, no out_valid rises, sel_err=1 for exactly one cycle.
- Fill every channel with out_ready=0, assert rst for one cycle mid-stream -> all out_valid=0, out_data=0, rr_ptr=0 next cycle; a new word to channel 1 is then accepted normally.
- WIDTH=16, CH=8: simultaneous drain and accept on channel 5 every cycle for 10 cycles -> out_valid[5] stays 1 and out_data slice 5 updates each cycle with no bubble.

Source files
------------

// File: rtl/demux_stream_if.sv
// Stream bundle for demux_stream: one producer port and CH consumer ports.
// slave is the demux side, master the producer/consumer side.
interface demux_stream_if #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SELW  = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic [SELW-1:0]       in_sel;
    logic                  mode;
    logic [CH-1:0]         out_valid;
    logic [CH-1:0]         out_ready;
    logic [CH*WIDTH-1:0]   out_data;
    logic [SELW-1:0]       rr_ptr;
    logic                  sel_err;

    modport slave (
        input  in_valid, in_data, in_sel, mode, out_ready,
        output in_ready, out_valid, out_data, rr_ptr, sel_err
    );

    modport master (
        output in_valid, in_data, in_sel, mode, out_ready,
        input  in_ready, out_valid, out_data, rr_ptr, sel_err
    );
endinterface

// File: rtl/demux_stream.sv
// Registered 1-to-CH stream demux, explicit or round-robin routing,
// with a one-entry holding register per output channel.
module demux_stream #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SELW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    demux_stream_if.slave bus
);
    typedef enum logic {EMPTY, FULL} st_t;

    st_t              st_q [CH];
    st_t              st_d [CH];
    logic [WIDTH-1:0] data_q [CH];
    logic [SELW-1:0]  rr_q;
    logic [SELW-1:0]  rr_d;
    logic             err_q;

    logic [SELW-1:0]  tgt;
    logic             tgt_ok;
    logic [CH-1:0]    hit;
    logic [CH-1:0]    vld;
    logic [CH-1:0]    load;
    logic             acc;

    always_comb begin
        tgt    = bus.mode ? rr_q : bus.in_sel;
        tgt_ok = 32'(tgt) < CH;
        for (int i = 0; i < CH; i++) begin
            hit[i] = tgt_ok && (tgt == SELW'(i));
            vld[i] = (st_q[i] == FULL);
        end
    end

    // Out-of-range targets are always ready so the word is consumed.
    assign bus.in_ready = !tgt_ok
                        | (|(hit & (~vld | bus.out_ready)));
    assign acc  = bus.in_valid & bus.in_ready;
    assign load = hit & {CH{acc}};

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            st_d[i] = st_q[i];
            unique case (st_q[i])
                EMPTY: if (load[i]) st_d[i] = FULL;
                FULL:  if (bus.out_ready[i] && !load[i])
                           st_d[i] = EMPTY;
                default: st_d[i] = EMPTY;
            endcase
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (acc && bus.mode) begin
            if (32'(rr_q) == CH - 1)
                rr_d = '0;
            else
                rr_d = rr_q + SELW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                st_q[i]   <= EMPTY;
                data_q[i] <= '0;
            end
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                st_q[i] <= st_d[i];
                if (load[i])
                    data_q[i] <= bus.in_data;
            end
            rr_q  <= rr_d;
            err_q <= acc && !tgt_ok;
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < CH; i++)
            bus.out_data[i*WIDTH +: WIDTH] = data_q[i];
    end

    assign bus.out_valid = vld;
    assign bus.rr_ptr    = rr_q;
    assign bus.sel_err   = err_q;
endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: three configurations, per-channel scoreboards
// fed on accept and drained on each output handshake.
module tb_demux_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    demux_stream_if #(.WIDTH(8), .CH(4), .SELW(2)) bus_a ();
    demux_stream_if #(.WIDTH(8), .CH(3), .SELW(2)) bus_b ();
    demux_stream_if #(.WIDTH(16), .CH(8), .SELW(3)) bus_c ();

    demux_stream #(.WIDTH(8), .CH(4), .SELW(2)) u_a (
        .clk(clk), .rst(rst), .bus(bus_a));
    demux_stream #(.WIDTH(8), .CH(3), .SELW(2)) u_b (
        .clk(clk), .rst(rst), .bus(bus_b));
    demux_stream #(.WIDTH(16), .CH(8), .SELW(3)) u_c (
        .clk(clk), .rst(rst), .bus(bus_c));

    logic [7:0]  qa [4][$];
    logic [15:0] qc [8][$];
    int          m_rr = 0;
    logic [7:0]  ea;
    logic [15:0] ec;
    int          t;

    // Scoreboards: drain checks first, then record this cycle's accept.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) qa[i].delete();
            for (int i = 0; i < 8; i++) qc[i].delete();
            m_rr = 0;
        end else begin
            total++;
            if (bus_a.rr_ptr !== 2'(m_rr)) begin
                bad++;
                $display("FAIL sb_rr_ptr got=%0d want=%0d",
                         bus_a.rr_ptr, m_rr);
            end
            for (int i = 0; i < 4; i++) begin
                if (bus_a.out_valid[i] && bus_a.out_ready[i]) begin
                    total++;
                    if (qa[i].size() == 0) begin
                        bad++;
                        $display("FAIL sb_a_ch%0d got=%h want=none",
                                 i, bus_a.out_data[i*8 +: 8]);
                    end else begin
                        ea = qa[i].pop_front();
                        if (bus_a.out_data[i*8 +: 8] !== ea) begin
                            bad++;
                            $display("FAIL sb_a_ch%0d got=%h want=%h",
                                     i, bus_a.out_data[i*8 +: 8], ea);
                        end
                    end
                end
            end
            if (bus_a.in_valid && bus_a.in_ready) begin
                t = bus_a.mode ? m_rr : int'(bus_a.in_sel);
                qa[t].push_back(bus_a.in_data);
                if (bus_a.mode) m_rr = (m_rr + 1) % 4;
            end
            for (int i = 0; i < 8; i++) begin
                if (bus_c.out_valid[i] && bus_c.out_ready[i]) begin
                    total++;
                    if (qc[i].size() == 0) begin
                        bad++;
                        $display("FAIL sb_c_ch%0d got=%h want=none",
                                 i, bus_c.out_data[i*16 +: 16]);
                    end else begin
                        ec = qc[i].pop_front();
                        if (bus_c.out_data[i*16 +: 16] !== ec) begin
                            bad++;
                            $display("FAIL sb_c_ch%0d got=%h want=%h",
                                     i, bus_c.out_data[i*16 +: 16], ec);
                        end
                    end
                end
            end
            if (bus_c.in_valid && bus_c.in_ready)
                qc[int'(bus_c.in_sel)].push_back(bus_c.in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        total++;
        if (bus_a.out_valid !== 4'h0 || bus_a.out_data !== 32'h0 ||
            bus_a.rr_ptr !== 2'd0 || bus_a.sel_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_a got v=%h d=%h rr=%0d e=%b want 0",
                     bus_a.out_valid, bus_a.out_data,
                     bus_a.rr_ptr, bus_a.sel_err);
        end
        total++;
        if (bus_b.out_valid !== 3'h0 || bus_b.sel_err !== 1'b0 ||
            bus_c.out_valid !== 8'h0 || bus_c.out_data !== 128'h0) begin
            bad++;
            $display("FAIL reset_bc got vb=%h eb=%b vc=%h want 0",
                     bus_b.out_valid, bus_b.sel_err, bus_c.out_valid);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus_a.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=1",
                     bus_a.in_ready);
        end
    endtask

    task automatic test_explicit();
        logic [7:0] d;
        bus_a.out_ready = 4'hF;
        bus_a.mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d = 8'hA0 + 8'(k);
            bus_a.in_valid = 1'b1;
            bus_a.in_sel = 2'(k);
            bus_a.in_data = d;
            #1;
            total++;
            if (bus_a.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL explicit_ready%0d got=%b want=1",
                         k, bus_a.in_ready);
            end
            tick();
            total++;
            if (bus_a.out_valid !== 4'(1 << k) ||
                bus_a.out_data[k*8 +: 8] !== d) begin
                bad++;
                $display("FAIL explicit_out%0d got=%h/%h want=%h/%h", k,
                         bus_a.out_valid, bus_a.out_data[k*8 +: 8],
                         4'(1 << k), d);
            end
        end
        bus_a.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        bus_a.out_ready = 4'b1011;
        bus_a.in_valid = 1'b1;
        bus_a.in_sel = 2'd2;
        bus_a.in_data = 8'h21;
        tick();
        bus_a.in_data = 8'h22;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (bus_a.in_ready !== 1'b0 || bus_a.out_valid[2] !== 1'b1 ||
                bus_a.out_data[23:16] !== 8'h21) begin
                bad++;
                $display("FAIL bp_hold%0d got r=%b v=%b d=%h want 0/1/21",
                         k, bus_a.in_ready, bus_a.out_valid[2],
                         bus_a.out_data[23:16]);
            end
            tick();
        end
        bus_a.in_sel = 2'd0;
        bus_a.in_data = 8'h30;
        #1;
        total++;
        if (bus_a.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_other_ready got=%b want=1", bus_a.in_ready);
        end
        tick();
        total++;
        if (bus_a.out_valid !== 4'b0101 || bus_a.out_data[7:0] !== 8'h30) begin
            bad++;
            $display("FAIL bp_other_out got=%h/%h want=5/30",
                     bus_a.out_valid, bus_a.out_data[7:0]);
        end
        bus_a.in_sel = 2'd2;
        bus_a.in_data = 8'h22;
        bus_a.out_ready = 4'hF;
        #1;
        total++;
        if (bus_a.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got=%b want=1", bus_a.in_ready);
        end
        tick();
        total++;
        if (bus_a.out_valid !== 4'b0100 ||
            bus_a.out_data[23:16] !== 8'h22) begin
            bad++;
            $display("FAIL bp_second got=%h/%h want=4/22",
                     bus_a.out_valid, bus_a.out_data[23:16]);
        end
        bus_a.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int ch;
        bus_a.out_ready = 4'hF;
        bus_a.mode = 1'b1;
        bus_a.in_sel = 2'd3;
        for (int k = 0; k < 6; k++) begin
            ch = k % 4;
            bus_a.in_valid = 1'b1;
            bus_a.in_data = 8'hD0 + 8'(k);
            tick();
            total++;
            if (bus_a.out_valid !== 4'(1 << ch) ||
                bus_a.out_data[ch*8 +: 8] !== 8'hD0 + 8'(k)) begin
                bad++;
                $display("FAIL rr_word%0d got=%h want=%h",
                         k, bus_a.out_valid, 4'(1 << ch));
            end
        end
        total++;
        if (bus_a.rr_ptr !== 2'd2) begin
            bad++;
            $display("FAIL rr_end got=%0d want=2", bus_a.rr_ptr);
        end
        bus_a.mode = 1'b0;
        bus_a.in_data = 8'hE3;
        tick();
        total++;
        if (bus_a.out_valid !== 4'b1000 || bus_a.rr_ptr !== 2'd2) begin
            bad++;
            $display("FAIL rr_hold got v=%h rr=%0d want 8/2",
                     bus_a.out_valid, bus_a.rr_ptr);
        end
        bus_a.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_sel_err();
        bus_b.out_ready = 3'h7;
        bus_b.mode = 1'b0;
        bus_b.in_valid = 1'b1;
        bus_b.in_sel = 2'd3;
        bus_b.in_data = 8'h77;
        #1;
        total++;
        if (bus_b.in_ready !== 1'b1 || bus_b.sel_err !== 1'b0) begin
            bad++;
            $display("FAIL selerr_ready got r=%b e=%b want 1/0",
                     bus_b.in_ready, bus_b.sel_err);
        end
        tick();
        bus_b.in_valid = 1'b0;
        total++;
        if (bus_b.sel_err !== 1'b1 || bus_b.out_valid !== 3'h0) begin
            bad++;
            $display("FAIL selerr_pulse got e=%b v=%h want 1/0",
                     bus_b.sel_err, bus_b.out_valid);
        end
        tick();
        total++;
        if (bus_b.sel_err !== 1'b0 || bus_b.out_valid !== 3'h0) begin
            bad++;
            $display("FAIL selerr_clear got e=%b v=%h want 0/0",
                     bus_b.sel_err, bus_b.out_valid);
        end
        bus_b.in_valid = 1'b1;
        bus_b.in_sel = 2'd2;
        tick();
        bus_b.in_valid = 1'b0;
        total++;
        if (bus_b.sel_err !== 1'b0 || bus_b.out_valid !== 3'b100 ||
            bus_b.out_data[23:16] !== 8'h77) begin
            bad++;
            $display("FAIL selerr_valid got e=%b v=%h want 0/4",
                     bus_b.sel_err, bus_b.out_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus_a.out_ready = 4'h0;
        bus_a.mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_sel = 2'(k);
            bus_a.in_data = 8'h50 + 8'(k);
            tick();
        end
        bus_a.in_valid = 1'b0;
        total++;
        if (bus_a.out_valid !== 4'hF) begin
            bad++;
            $display("FAIL mid_fill got=%h want=f", bus_a.out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus_a.out_valid !== 4'h0 || bus_a.out_data !== 32'h0 ||
            bus_a.rr_ptr !== 2'd0 || bus_a.sel_err !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got v=%h d=%h rr=%0d want 0",
                     bus_a.out_valid, bus_a.out_data, bus_a.rr_ptr);
        end
        bus_a.in_valid = 1'b1;
        bus_a.in_sel = 2'd1;
        bus_a.in_data = 8'h61;
        #1;
        total++;
        if (bus_a.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_ready got=%b want=1", bus_a.in_ready);
        end
        tick();
        bus_a.in_valid = 1'b0;
        total++;
        if (bus_a.out_valid !== 4'b0010 || bus_a.out_data[15:8] !== 8'h61) begin
            bad++;
            $display("FAIL mid_new got=%h/%h want=2/61",
                     bus_a.out_valid, bus_a.out_data[15:8]);
        end
        bus_a.out_ready = 4'hF;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        bus_c.out_ready = 8'h20;
        bus_c.mode = 1'b0;
        bus_c.in_sel = 3'd5;
        for (int k = 0; k < 10; k++) begin
            d = 16'h5A00 + 16'(k * 3);
            bus_c.in_valid = 1'b1;
            bus_c.in_data = d;
            #1;
            total++;
            if (bus_c.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready%0d got=%b want=1",
                         k, bus_c.in_ready);
            end
            tick();
            total++;
            if (bus_c.out_valid !== 8'h20 ||
                bus_c.out_data[80 +: 16] !== d) begin
                bad++;
                $display("FAIL b2b_out%0d got=%h/%h want=20/%h", k,
                         bus_c.out_valid, bus_c.out_data[80 +: 16], d);
            end
        end
        bus_c.in_valid = 1'b0;
        tick();
        total++;
        if (bus_c.out_valid !== 8'h00) begin
            bad++;
            $display("FAIL b2b_drain got=%h want=0", bus_c.out_valid);
        end
    endtask

    task automatic test_drained();
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (qa[i].size() != 0) begin
                bad++;
                $display("FAIL left_a_ch%0d got=%0d want=0",
                         i, qa[i].size());
            end
        end
    endtask

    initial begin
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_sel = '0;
        bus_a.mode = 1'b0;     bus_a.out_ready = '1;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_sel = '0;
        bus_b.mode = 1'b0;     bus_b.out_ready = '1;
        bus_c.in_valid = 1'b0; bus_c.in_data = '0; bus_c.in_sel = '0;
        bus_c.mode = 1'b0;     bus_c.out_ready = '1;
        test_reset();
        test_explicit();
        test_backpressure();
        test_round_robin();
        test_sel_err();
        test_reset_mid();
        test_back_to_back();
        test_drained();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
